// File: rtl/tdm_mux8x1.sv
// 8:1 time-division multiplexer: captures I1..I8 as a frame and sends one bit per slot on Y
// with the slot index on S2..S0, so a 1x8 demux can rebuild the frame.
module tdm_mux8x1 #(
    parameter int unsigned HOLD = 1
) (
    input  logic CLK,
    input  logic RST,
    input  logic EN,
    input  logic LOAD,
    input  logic I1,
    input  logic I2,
    input  logic I3,
    input  logic I4,
    input  logic I5,
    input  logic I6,
    input  logic I7,
    input  logic I8,
    output logic Y,
    output logic S2,
    output logic S1,
    output logic S0,
    output logic FRAME,
    output logic BUSY,
    output logic DONE
);

    localparam int unsigned HW = 8;
    localparam int unsigned SW = 3;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(7);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t          state, nxt_state;
    logic [SW-1:0]   slot, nxt_slot;
    logic [HW-1:0]   hold, nxt_hold;
    logic [7:0]      shadow, nxt_shadow;
    logic [7:0]      frame_in;

    logic            nxt_y;
    logic [SW-1:0]   nxt_s;
    logic            nxt_frame;
    logic            nxt_busy;
    logic            nxt_done;

    assign frame_in = {I8, I7, I6, I5, I4, I3, I2, I1};

    // Next-state, counters and shadow; EN low leaves everything as is.
    always_comb begin
        nxt_state  = state;
        nxt_slot   = slot;
        nxt_hold   = hold;
        nxt_shadow = shadow;
        if (EN) begin
            unique case (state)
                IDLE: begin
                    if (LOAD) begin
                        nxt_state  = SEND;
                        nxt_slot   = '0;
                        nxt_hold   = '0;
                        nxt_shadow = frame_in;
                    end
                end
                SEND: begin
                    if (hold != HOLD_LAST) begin
                        nxt_hold = hold + HW'(1);
                    end else if (slot != SLOT_LAST) begin
                        nxt_hold = '0;
                        nxt_slot = slot + SW'(1);
                    end else begin
                        nxt_hold = '0;
                        nxt_slot = '0;
                        if (LOAD) begin
                            nxt_shadow = frame_in;
                        end else begin
                            nxt_state = IDLE;
                        end
                    end
                end
                default: nxt_state = IDLE;
            endcase
        end
    end

    // Output values for the next cycle, decoded from the next state so the ports are registered.
    always_comb begin
        nxt_busy  = (nxt_state == SEND);
        nxt_y     = 1'b0;
        nxt_s     = '0;
        nxt_frame = 1'b0;
        nxt_done  = 1'b0;
        if (nxt_busy) begin
            nxt_y     = nxt_shadow[nxt_slot];
            nxt_s     = nxt_slot;
            nxt_frame = (nxt_slot == '0);
            nxt_done  = (nxt_slot == SLOT_LAST) && (nxt_hold == HOLD_LAST);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            slot   <= '0;
            hold   <= '0;
            shadow <= '0;
            Y      <= 1'b0;
            S2     <= 1'b0;
            S1     <= 1'b0;
            S0     <= 1'b0;
            FRAME  <= 1'b0;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
        end else begin
            state  <= nxt_state;
            slot   <= nxt_slot;
            hold   <= nxt_hold;
            shadow <= nxt_shadow;
            Y      <= nxt_y;
            S2     <= nxt_s[2];
            S1     <= nxt_s[1];
            S0     <= nxt_s[0];
            FRAME  <= nxt_frame;
            BUSY   <= nxt_busy;
            DONE   <= nxt_done;
        end
    end

endmodule

// File: tb/tb_tdm_mux8x1.sv
// Bench for tdm_mux8x1: HOLD=1 and HOLD=3 instances share stimulus and are checked each cycle
// against a frame-position model, plus directed literal checks.
module tb_tdm_mux8x1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst  = 1'b1;
    logic       en   = 1'b1;
    logic       load = 1'b0;
    logic [7:0] din  = 8'h00;

    logic y1, s21, s11, s01, fr1, bz1, dn1;
    logic y3, s23, s13, s03, fr3, bz3, dn3;
    logic [6:0] o1, o3;
    assign o1 = {y1, s21, s11, s01, fr1, bz1, dn1};
    assign o3 = {y3, s23, s13, s03, fr3, bz3, dn3};

    tdm_mux8x1 #(.HOLD(1)) dut1 (
        .CLK(clk), .RST(rst), .EN(en), .LOAD(load),
        .I1(din[0]), .I2(din[1]), .I3(din[2]), .I4(din[3]),
        .I5(din[4]), .I6(din[5]), .I7(din[6]), .I8(din[7]),
        .Y(y1), .S2(s21), .S1(s11), .S0(s01),
        .FRAME(fr1), .BUSY(bz1), .DONE(dn1)
    );

    tdm_mux8x1 #(.HOLD(3)) dut3 (
        .CLK(clk), .RST(rst), .EN(en), .LOAD(load),
        .I1(din[0]), .I2(din[1]), .I3(din[2]), .I4(din[3]),
        .I5(din[4]), .I6(din[5]), .I7(din[6]), .I8(din[7]),
        .Y(y3), .S2(s23), .S1(s13), .S0(s03),
        .FRAME(fr3), .BUSY(bz3), .DONE(dn3)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a frame is a cycle position 0..8*HOLD-1; slot = pos / HOLD.
    int         hv[2] = '{1, 3};
    bit         mb[2];
    int         mp[2];
    logic [7:0] mbits[2];
    bit         started = 1'b0;

    always @(posedge clk) begin
        started = 1'b1;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                mb[d] = 1'b0;
                mp[d] = 0;
            end else if (en) begin
                if (!mb[d]) begin
                    if (load) begin
                        mb[d] = 1'b1; mp[d] = 0; mbits[d] = din;
                    end
                end else if (mp[d] == 8 * hv[d] - 1) begin
                    if (load) begin
                        mp[d] = 0; mbits[d] = din;
                    end else begin
                        mb[d] = 1'b0;
                    end
                end else begin
                    mp[d]++;
                end
            end
        end
    end

    function automatic logic [6:0] expv(input int d);
        int slot;
        if (!mb[d]) return 7'd0;
        slot = mp[d] / hv[d];
        return {mbits[d][slot], 3'(slot), slot == 0, 1'b1, mp[d] == 8 * hv[d] - 1};
    endfunction

    always @(negedge clk) begin
        if (started) begin
            check("cycle_h1", 32'(o1), 32'(expv(0)));
            check("cycle_h3", 32'(o3), 32'(expv(1)));
        end
    end

    initial begin
        logic [7:0]  ycap;
        logic [7:0]  m;
        logic [15:0] y16;
        logic        bzall;
        int          busycnt, donecnt, s4cnt, s0cnt;

        // Reset, then idle with LOAD low
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            check("idle_zero", 32'(o1), 32'd0);
        end

        // Single frame, HOLD=1
        din = 8'b1011_0010; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        m = 8'h00;
        for (int k = 0; k < 8; k++) begin
            check("single_slot", 32'({s21, s11, s01}), 32'(k));
            check("single_frame", 32'(fr1), 32'(k == 0));
            check("single_done", 32'(dn1), 32'(k == 7));
            ycap[k] = y1;
            m[{s21, s11, s01}] = y1;
            @(negedge clk);
        end
        check("single_y_seq", 32'(ycap), 32'hB2);
        check("single_demux", 32'(m), 32'hB2);
        check("single_busy_fall", 32'(bz1), 32'd0);
        repeat (24) @(negedge clk);

        // Back-to-back with LOAD held; inputs switched mid-frame
        din = 8'hA5; load = 1'b1;
        @(negedge clk);
        bzall = 1'b1;
        for (int k = 0; k < 16; k++) begin
            y16[k] = y1;
            bzall &= bz1;
            if (k == 3)  din = 8'h3C;
            if (k == 15) load = 1'b0;
            @(negedge clk);
        end
        check("b2b_y_seq", 32'(y16), 32'h3CA5);
        check("b2b_busy_held", 32'(bzall), 32'd1);
        check("b2b_busy_fall", 32'(bz1), 32'd0);
        repeat (12) @(negedge clk);

        // LOAD pulse mid-frame is ignored
        din = 8'h5A; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int k = 0; k < 8; k++) begin
            ycap[k] = y1;
            if (k == 3) begin load = 1'b1; din = 8'hFF; end
            if (k == 4) load = 1'b0;
            @(negedge clk);
        end
        check("midload_y_seq", 32'(ycap), 32'h5A);
        check("midload_busy_fall", 32'(bz1), 32'd0);
        repeat (30) @(negedge clk);

        // HOLD=3 with a two-cycle EN stall in slot 4
        din = 8'hFF; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        busycnt = 0; donecnt = 0; s4cnt = 0; s0cnt = 0;
        for (int k = 0; k < 60; k++) begin
            if (!bz3) break;
            busycnt++;
            donecnt += int'(dn3);
            if ({s23, s13, s03} == 3'd4) s4cnt++;
            if ({s23, s13, s03} == 3'd0) s0cnt++;
            if (k == 13) en = 1'b0;
            if (k == 15) en = 1'b1;
            @(negedge clk);
        end
        check("stall_frame_len", 32'(busycnt), 32'd26);
        check("stall_done_cnt", 32'(donecnt), 32'd1);
        check("stall_slot4_len", 32'(s4cnt), 32'd5);
        check("stall_slot0_len", 32'(s0cnt), 32'd3);
        repeat (5) @(negedge clk);

        // Reset during slot 5, release with LOAD high
        din = 8'h00; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_pre_slot", 32'({s21, s11, s01}), 32'd5);
        rst = 1'b1; load = 1'b1; din = 8'h81;
        @(negedge clk);
        check("rst_zero_h1", 32'(o1), 32'd0);
        check("rst_zero_h3", 32'(o3), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        load = 1'b0;
        check("rst_new_frame", 32'(fr1), 32'd1);
        for (int k = 0; k < 8; k++) begin
            ycap[k] = y1;
            @(negedge clk);
        end
        check("rst_y_seq", 32'(ycap), 32'h81);
        repeat (30) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tdm_mux8x1.md
# tdm_mux8x1

Transmit-side counterpart of the 1x8 demultiplexer. The block captures eight parallel input bits as one frame and sends them one slot at a time on a single serial line. Alongside each bit it drives the 3-bit slot select (S2..S0), so a downstream demux1x8 fed with Y, S2, S1 and S0 rebuilds the eight bits on m1..m8. Frames are started with a LOAD request and can run back-to-back with no idle gap.

## Interface
Parameters:
- HOLD, default 1: clock cycles each slot is held on Y/S; legal range 1..255.

Ports:
- CLK  input  1  clock; every register updates on the rising edge.
- RST  input  1  reset; synchronous and active-high.
- EN  input  1  global enable; when low, all state freezes (no capture, no slot advance).
- LOAD  input  1  frame request; sampled on each rising edge.
- I1..I8  input  1 each  parallel frame bits; I1 maps to slot 0, I8 to slot 7.
- Y  output  1  serial data for the current slot.
- S2, S1, S0  output  1 each  current slot index; S2 is the MSB.
- FRAME  output  1  high during every cycle of slot 0 while BUSY.
- BUSY  output  1  a frame is being transmitted.
- DONE  output  1  high during the final cycle of slot 7.

## Operation
- States:
  - IDLE: no frame in progress.
  - SEND: a frame is in progress, tracked by a 3-bit slot counter and a hold counter that counts 0..HOLD-1.
- Reset: state is IDLE, the shadow register is cleared, and every output is 0 (Y=0, S=000, FRAME=0, BUSY=0, DONE=0).
- Leaving IDLE:
  - IDLE with EN=1 and LOAD=1: capture I1..I8 into the 8-bit shadow register, go to SEND, slot=0, hold=0.
  - IDLE with LOAD=0 or EN=0: stay in IDLE.
- Outputs in SEND:
  - Y = shadow[slot].
  - {S2,S1,S0} = slot.
  - BUSY=1.
  - FRAME = (slot==0).
  - DONE = (slot==7 && hold==HOLD-1).
- Outputs in IDLE: Y=0, S=000, FRAME=0, BUSY=0, DONE=0.
- Advancing in SEND with EN=1:
  - If hold<HOLD-1: hold increments.
  - Otherwise: hold goes to 0 and slot increments.
- End of frame (in SEND, EN=1, DONE=1):
  - LOAD=1: recapture I1..I8, slot=0, hold=0, stay in SEND. The new frame starts with no gap.
  - LOAD=0: go to IDLE.
- LOAD while BUSY is ignored in every cycle except the DONE cycle. The shadow register is never overwritten mid-frame, so I1..I8 may change freely during transmission.
- EN=0 in any state:
  - State, counters and shadow register hold.
  - Outputs keep their current values, including DONE if it is already high.
  - LOAD is ignored.
- RST=1 has priority over everything. A frame interrupted by reset is discarded, and outputs are 0 in the cycle after the reset edge.
- The slot counter never wraps inside a frame. The value 7 is always followed by IDLE or by a new slot 0.

## Timing
- Latency:
  - LOAD=1 sampled at edge t (EN=1) gives BUSY=1, S=000, Y=I1(t), FRAME=1 in the cycle after edge t.
  - Capture samples I1..I8 at edge t.
- Frame length: 8*HOLD cycles. With HOLD=1, slot k occupies cycle t+1+k and DONE is high in cycle t+8.
- Back-to-back frames: LOAD high at the DONE edge puts slot 0 of the next frame in the following cycle. BUSY stays 1 continuously.
- After a frame ends without a new LOAD, BUSY falls in the cycle after DONE.
- All outputs are registered or decoded directly from registered state. There is no combinational path from any input to any output.
- Each EN=0 cycle stretches the current slot by exactly one cycle.

## Test plan
- Reset/idle:
  - Stimulus: RST=1 for 2 cycles, then release with LOAD=0.
  - Required response: Y, S, FRAME, BUSY and DONE are all 0 and stay 0 for 20 cycles.
- Single frame, HOLD=1:
  - Stimulus: I8..I1=8'b1011_0010, one LOAD pulse.
  - Required response: Y sequence 0,1,0,0,1,1,0,1 with S counting 000..111.
  - FRAME high only in the first cycle, DONE high only in the eighth.
  - BUSY falls in the next cycle.
  - A demux1x8 driven by Y/S reproduces the bits on m1..m8.
- Back-to-back frames and input isolation:
  - Stimulus: hold LOAD=1 continuously; frame A=8'hA5, switch inputs to B=8'h3C mid-frame.
  - Required response: frame A is sent unchanged, then B starts with no gap; BUSY never drops.
  - A LOAD pulse sent mid-frame has no effect.
- HOLD=3 with an EN stall:
  - Stimulus: frame 8'hFF; drop EN for 2 cycles during slot 4.
  - Required response: each slot lasts 3 cycles, slot 4 lasts 5.
  - Total frame length is 26 cycles and DONE is high for 1 cycle.
- Reset mid-frame:
  - Stimulus: assert RST during slot 5, then release while LOAD=1 with input 8'h81.
  - Required response: outputs are 0 in the cycle after the reset edge.
  - The new frame starts cleanly at slot 0 with Y=1 in slots 0 and 7 only.
